// File: rtl/stats_pkg.sv
// Shared encodings for the statistics counter bank.
// No logic: FSM state type and op-type constants only.
// No flow control of its own.
package stats_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    localparam logic OP_INC = 1'b0;
    localparam logic OP_RD  = 1'b1;

endpackage

// File: rtl/stats_counter_ram.sv
// Single-port counter storage with write enable and registered read data.
// Latency: read data valid one cycle after the address is presented.
// Backpressure: none, accepts one access per cycle.
module stats_counter_ram #(
    parameter int AW = 5,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    (* ram_style = "distributed" *) logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/stats_counter_bank.sv
// Per-ID wide statistics counters with increment stream and clear-on-read CSR port.
// Latency: accept at T, counter update / read response at T+2, next accept at T+3.
// Backpressure: both readies low except in IDLE; increments and reads alternate when both pending.
module stats_counter_bank
    import stats_pkg::*;
#(
    parameter int STAT_INC_WIDTH   = 16,
    parameter int STAT_ID_WIDTH    = 5,
    parameter int STAT_COUNT_WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [STAT_INC_WIDTH-1:0]   s_axis_stat_tdata,
    input  logic [STAT_ID_WIDTH-1:0]    s_axis_stat_tid,
    input  logic                        s_axis_stat_tvalid,
    output logic                        s_axis_stat_tready,
    input  logic [STAT_ID_WIDTH-1:0]    rd_req_addr,
    input  logic                        rd_req_clear,
    input  logic                        rd_req_valid,
    output logic                        rd_req_ready,
    output logic [STAT_COUNT_WIDTH-1:0] rd_resp_data,
    output logic                        rd_resp_valid
);

    localparam logic [STAT_ID_WIDTH-1:0] LAST_ID = '1;

    state_t                      state, state_nxt;
    logic [STAT_ID_WIDTH-1:0]    init_ptr;
    logic [STAT_ID_WIDTH-1:0]    addr_q;
    logic [STAT_INC_WIDTH-1:0]   inc_q;
    logic                        clear_q;
    logic                        op_q;
    logic                        prio;
    logic [STAT_COUNT_WIDTH-1:0] resp_q;

    logic                        grant_inc;
    logic                        grant_rd;
    logic                        ram_we;
    logic [STAT_ID_WIDTH-1:0]    ram_addr;
    logic [STAT_COUNT_WIDTH-1:0] ram_wdata;
    logic [STAT_COUNT_WIDTH-1:0] ram_rdata;

    // prio=0 favours increments, prio=1 favours reads; only matters when both are pending
    always_comb begin
        grant_inc = 1'b0;
        grant_rd  = 1'b0;
        if (state == ST_IDLE) begin
            grant_inc = s_axis_stat_tvalid && (!rd_req_valid || !prio);
            grant_rd  = rd_req_valid && (!s_axis_stat_tvalid || prio);
        end
    end

    assign s_axis_stat_tready = grant_inc;
    assign rd_req_ready       = grant_rd;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:  if (init_ptr == LAST_ID) state_nxt = ST_IDLE;
            ST_IDLE:  if (grant_inc || grant_rd) state_nxt = ST_READ;
            ST_READ:  state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = ST_IDLE;
            default:  state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = addr_q;
        ram_wdata = '0;
        case (state)
            ST_INIT: begin
                ram_we   = 1'b1;
                ram_addr = init_ptr;
            end
            ST_WRITE: begin
                if (op_q == OP_INC) begin
                    ram_we    = 1'b1;
                    ram_wdata = ram_rdata + STAT_COUNT_WIDTH'(inc_q);
                end else if (clear_q) begin
                    ram_we = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_ptr <= '0;
            addr_q   <= '0;
            inc_q    <= '0;
            clear_q  <= 1'b0;
            op_q     <= OP_INC;
            prio     <= 1'b0;
            resp_q   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) begin
                init_ptr <= init_ptr + 1'b1;
            end
            if (grant_inc) begin
                addr_q  <= s_axis_stat_tid;
                inc_q   <= s_axis_stat_tdata;
                clear_q <= 1'b0;
                op_q    <= OP_INC;
                prio    <= 1'b1;
            end else if (grant_rd) begin
                addr_q  <= rd_req_addr;
                inc_q   <= '0;
                clear_q <= rd_req_clear;
                op_q    <= OP_RD;
                prio    <= 1'b0;
            end
            if (rd_resp_valid) begin
                resp_q <= ram_rdata;
            end
        end
    end

    // Response data bypasses the RAM output during the strobe, then holds that value
    assign rd_resp_valid = (state == ST_WRITE) && (op_q == OP_RD);
    assign rd_resp_data  = rd_resp_valid ? ram_rdata : resp_q;

    stats_counter_ram #(
        .AW (STAT_ID_WIDTH),
        .DW (STAT_COUNT_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_stats_counter_bank.sv
// Directed bench: 64-bit bank plus a 16-bit bank on the same stimulus for wrap checks.
module tb_stats_counter_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] tdata;
    logic [4:0]  tid;
    logic        tvalid;
    logic        tready;
    logic [4:0]  rd_req_addr;
    logic        rd_req_clear;
    logic        rd_req_valid;
    logic        rd_req_ready;
    logic [63:0] rd_resp_data;
    logic        rd_resp_valid;

    logic        tready_w;
    logic        rd_req_ready_w;
    logic [15:0] rd_resp_data_w;
    logic        rd_resp_valid_w;

    typedef struct {
        logic [63:0] val;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [63:0] model [32];
    bit          exp_prio;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    stats_counter_bank #(
        .STAT_INC_WIDTH (16), .STAT_ID_WIDTH (5), .STAT_COUNT_WIDTH (64)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .s_axis_stat_tdata (tdata), .s_axis_stat_tid (tid),
        .s_axis_stat_tvalid (tvalid), .s_axis_stat_tready (tready),
        .rd_req_addr (rd_req_addr), .rd_req_clear (rd_req_clear),
        .rd_req_valid (rd_req_valid), .rd_req_ready (rd_req_ready),
        .rd_resp_data (rd_resp_data), .rd_resp_valid (rd_resp_valid)
    );

    stats_counter_bank #(
        .STAT_INC_WIDTH (16), .STAT_ID_WIDTH (5), .STAT_COUNT_WIDTH (16)
    ) dut_w (
        .clk (clk), .rst_n (rst_n),
        .s_axis_stat_tdata (tdata), .s_axis_stat_tid (tid),
        .s_axis_stat_tvalid (tvalid), .s_axis_stat_tready (tready_w),
        .rd_req_addr (rd_req_addr), .rd_req_clear (rd_req_clear),
        .rd_req_valid (rd_req_valid), .rd_req_ready (rd_req_ready_w),
        .rd_resp_data (rd_resp_data_w), .rd_resp_valid (rd_resp_valid_w)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Response checker: pops the scoreboard on every strobe
    always @(negedge clk) begin
        if (rst_n && rd_resp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 64'(sb.size()), 64'd1);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_cycle", 64'(cyc), 64'(mon_e.due));
                chk("resp_data", rd_resp_data, mon_e.val);
                chk("resp_data16", {48'b0, rd_resp_data_w}, {48'b0, mon_e.val[15:0]});
                chk("resp_valid16", {63'b0, rd_resp_valid_w}, 64'd1);
            end
        end
    end

    // Called just after a posedge; returns just after the accepting posedge
    task automatic do_inc(input logic [4:0] id, input logic [15:0] v);
        int n = 0;
        tid = id; tdata = v; tvalid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!tready && n < 20);
        chk("inc_grant", {63'b0, tready}, 64'd1);
        if (tready) begin
            model[id] = model[id] + 64'(v);
            exp_prio  = 1'b1;
        end
        @(posedge clk); #1;
        tvalid = 1'b0;
    endtask

    task automatic do_rd(input logic [4:0] id, input logic clr);
        int   n = 0;
        exp_t e;
        rd_req_addr = id; rd_req_clear = clr; rd_req_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!rd_req_ready && n < 20);
        chk("rd_grant", {63'b0, rd_req_ready}, 64'd1);
        if (rd_req_ready) begin
            e.val = model[id];
            e.due = cyc + 2;
            sb.push_back(e);
            if (clr) model[id] = '0;
            exp_prio = 1'b0;
        end
        @(posedge clk); #1;
        rd_req_valid = 1'b0;
        rd_req_clear = 1'b0;
    endtask

    // Holds both valids through INIT and counts the cycles with readies low
    task automatic init_wait();
        int n = 0;
        int rd_hi = 0;
        tid = 5'd0; tdata = 16'h0; tvalid = 1'b1;
        rd_req_addr = 5'd0; rd_req_clear = 1'b0; rd_req_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (tready || n > 100) break;
            if (rd_req_ready) rd_hi++;
            n++;
        end
        chk("init_cycles", 64'(n), 64'd32);
        chk("init_rd_ready_low", 64'(rd_hi), 64'd0);
        chk("init_first_grant", {62'b0, tready, rd_req_ready}, 64'b10);
        if (tready) exp_prio = 1'b1;
        @(posedge clk); #1;
        tvalid = 1'b0; rd_req_valid = 1'b0;
    endtask

    initial begin
        int   g;
        int   last;
        int   n;
        exp_t e;

        rst_n = 1'b0;
        tdata = '0; tid = '0; tvalid = 1'b0;
        rd_req_addr = '0; rd_req_clear = 1'b0; rd_req_valid = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        exp_prio = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tready", {63'b0, tready}, 64'd0);
        chk("rst_rd_req_ready", {63'b0, rd_req_ready}, 64'd0);
        chk("rst_resp_valid", {63'b0, rd_resp_valid}, 64'd0);
        chk("rst_resp_data", rd_resp_data, 64'd0);
        rst_n = 1'b1;
        init_wait();

        for (int i = 0; i < 32; i++) do_rd(5'(i), 1'b0);

        do_inc(5'd3, 16'h0010);
        do_inc(5'd3, 16'h0020);
        chk("model_acc", model[3], 64'h30);
        do_rd(5'd3, 1'b0);
        do_rd(5'd4, 1'b0);

        do_inc(5'd0, 16'hFFFF);
        do_inc(5'd0, 16'h0002);
        do_rd(5'd0, 1'b0);

        do_rd(5'd3, 1'b1);
        do_rd(5'd3, 1'b0);

        do_inc(5'd5, 16'h0000);
        do_rd(5'd5, 1'b0);

        // Both sides pending continuously: grants must alternate every 3 cycles
        tid = 5'd9; tdata = 16'h0005; tvalid = 1'b1;
        rd_req_addr = 5'd9; rd_req_clear = 1'b0; rd_req_valid = 1'b1;
        g = 0; last = -1; n = 0;
        while (g < 8 && n < 60) begin
            @(negedge clk);
            n++;
            if (tready || rd_req_ready) begin
                chk("arb_side", {62'b0, tready, rd_req_ready}, exp_prio ? 64'b01 : 64'b10);
                if (last >= 0) chk("arb_gap", 64'(cyc - last), 64'd3);
                last = cyc;
                if (tready) begin
                    model[9] = model[9] + 64'h5;
                    exp_prio = 1'b1;
                end else begin
                    e.val = model[9];
                    e.due = cyc + 2;
                    sb.push_back(e);
                    exp_prio = 1'b0;
                end
                g++;
            end
        end
        chk("arb_grants", 64'(g), 64'd8);
        @(posedge clk); #1;
        tvalid = 1'b0; rd_req_valid = 1'b0;
        do_rd(5'd9, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        // Reset while an increment to id 7 is in its WRITE cycle
        do_inc(5'd7, 16'h0055);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_resp_valid", {63'b0, rd_resp_valid}, 64'd0);
        chk("midrst_resp_data", rd_resp_data, 64'd0);
        chk("midrst_tready", {63'b0, tready}, 64'd0);
        sb.delete();
        for (int i = 0; i < 32; i++) model[i] = '0;
        exp_prio = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        init_wait();
        do_rd(5'd7, 1'b0);
        do_rd(5'd0, 1'b0);

        repeat (6) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
